// File: rtl/bnn_seq_ctrl_if.sv
// Handshake bundle between the BNN sequencer and its producers/consumer:
// weight-byte stream (cfg_*), input-vector stream (in_*) and result stream (out_*).
interface bnn_seq_ctrl_if #(
    parameter int IN_W  = 8,
    parameter int OUT_W = 4
);
    logic             cfg_valid;
    logic             cfg_ready;
    logic [7:0]       cfg_data;
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_data;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;

    modport master (
        output cfg_valid, cfg_data, in_valid, in_data, out_ready,
        input  cfg_ready, in_ready, out_valid, out_data
    );

    modport slave (
        input  cfg_valid, cfg_data, in_valid, in_data, out_ready,
        output cfg_ready, in_ready, out_valid, out_data
    );
endinterface

// File: rtl/bnn_seq_ctrl.sv
// Sequencer in front of the 8-8-4 BNN core: streams weight bytes as lo/hi nibbles
// after a one-cycle core reset, issues input vectors, waits out the core pipeline
// and returns each result over valid/ready.
// Ports: clk, reset (sync, active-high), ena (freeze), load_start (reload request),
//   bus (cfg/in/out handshakes, slave side), bnn_rst/bnn_x/bnn_wnib/bnn_load_en to
//   the core, bnn_y from the core, busy (not IDLE), load_done (pulse after reload).
module bnn_seq_ctrl #(
    parameter int NUM_NEURONS = 12,
    parameter int IN_W        = 8,
    parameter int OUT_W       = 4,
    parameter int PIPE_LAT    = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ena,
    input  logic             load_start,
    bnn_seq_ctrl_if.slave    bus,
    output logic             bnn_rst,
    output logic [IN_W-1:0]  bnn_x,
    output logic [3:0]       bnn_wnib,
    output logic             bnn_load_en,
    input  logic [OUT_W-1:0] bnn_y,
    output logic             busy,
    output logic             load_done
);
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_WRST    = 3'd1;
    localparam logic [2:0] S_LOAD_LO = 3'd2;
    localparam logic [2:0] S_LOAD_HI = 3'd3;
    localparam logic [2:0] S_INFER   = 3'd4;
    localparam logic [2:0] S_OUT     = 3'd5;

    // wait counter must reach PIPE_LAT without wrapping
    localparam int WW = $clog2(PIPE_LAT + 2);
    localparam logic [4:0]    LAST_BYTE = 5'(NUM_NEURONS - 1);
    localparam logic [WW-1:0] WAIT_END  = WW'(PIPE_LAT);

    logic [2:0]       state_q, state_d;
    logic             pend_q, pend_d;
    logic [4:0]       nbyte_q, nbyte_d;
    logic [WW-1:0]    wait_q, wait_d;
    logic [3:0]       hi_q, hi_d;
    logic [IN_W-1:0]  x_q, x_d;
    logic             ov_q, ov_d;
    logic [OUT_W-1:0] od_q, od_d;
    logic             done_q, done_d;

    logic             cfg_rdy;
    logic             in_rdy;
    logic             ld_en;
    logic [3:0]       wnib;
    logic             core_rst;

    always_comb begin
        state_d  = state_q;
        pend_d   = pend_q;
        nbyte_d  = nbyte_q;
        wait_d   = wait_q;
        hi_d     = hi_q;
        x_d      = x_q;
        ov_d     = ov_q;
        od_d     = od_q;
        done_d   = 1'b0;
        cfg_rdy  = 1'b0;
        in_rdy   = 1'b0;
        ld_en    = 1'b0;
        wnib     = 4'h0;
        core_rst = 1'b0;

        // ena low (or reset) freezes everything and keeps all strobes low
        if (ena && !reset) begin
            if (load_start) pend_d = 1'b1;
            case (state_q)
                S_IDLE: begin
                    in_rdy = ~pend_q & ~load_start & ~ov_q;
                    // a reload request takes priority over a waiting vector
                    if ((pend_q | load_start) && !ov_q) begin
                        pend_d  = 1'b0;
                        state_d = S_WRST;
                    end else if (bus.in_valid && in_rdy) begin
                        x_d     = bus.in_data;
                        wait_d  = '0;
                        state_d = S_INFER;
                    end
                end
                S_WRST: begin
                    core_rst = 1'b1;
                    nbyte_d  = 5'd0;
                    state_d  = S_LOAD_LO;
                end
                S_LOAD_LO: begin
                    cfg_rdy = 1'b1;
                    // without a byte, hold here so the core nibble phase is kept
                    if (bus.cfg_valid) begin
                        wnib    = bus.cfg_data[3:0];
                        ld_en   = 1'b1;
                        hi_d    = bus.cfg_data[7:4];
                        state_d = S_LOAD_HI;
                    end
                end
                S_LOAD_HI: begin
                    wnib    = hi_q;
                    ld_en   = 1'b1;
                    nbyte_d = nbyte_q + 5'd1;
                    if (nbyte_q == LAST_BYTE) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_LOAD_LO;
                    end
                end
                S_INFER: begin
                    wait_d = wait_q + WW'(1);
                    if (wait_q == WAIT_END) begin
                        od_d    = bnn_y;
                        ov_d    = 1'b1;
                        state_d = S_OUT;
                    end
                end
                S_OUT: begin
                    if (bus.out_ready) begin
                        ov_d    = 1'b0;
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            pend_q  <= 1'b0;
            nbyte_q <= 5'd0;
            wait_q  <= '0;
            hi_q    <= 4'h0;
            x_q     <= '0;
            ov_q    <= 1'b0;
            od_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            nbyte_q <= nbyte_d;
            wait_q  <= wait_d;
            hi_q    <= hi_d;
            x_q     <= x_d;
            ov_q    <= ov_d;
            od_q    <= od_d;
            done_q  <= done_d;
        end
    end

    assign bus.cfg_ready = cfg_rdy;
    assign bus.in_ready  = in_rdy;
    assign bus.out_valid = ov_q;
    assign bus.out_data  = od_q;
    assign bnn_rst       = core_rst;
    assign bnn_x         = x_q;
    assign bnn_wnib      = wnib;
    assign bnn_load_en   = ld_en;
    assign busy          = (state_q != S_IDLE);
    assign load_done     = done_q;
endmodule

// File: tb/tb_bnn_seq_ctrl.sv
// Directed bench for bnn_seq_ctrl with a behavioural 8-8-4 BNN core model:
// reset, reloads (back-to-back and stalled), inference latency/hold, priorities.
module tb_bnn_seq_ctrl;
    logic       clk = 1'b0;
    logic       reset;
    logic       ena;
    logic       load_start;
    logic       bnn_rst;
    logic [7:0] bnn_x;
    logic [3:0] bnn_wnib;
    logic       bnn_load_en;
    logic [3:0] bnn_y;
    logic       busy;
    logic       load_done;

    int n_tests = 0;
    int n_fail  = 0;

    bnn_seq_ctrl_if bus ();

    bnn_seq_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .ena        (ena),
        .load_start (load_start),
        .bus        (bus),
        .bnn_rst    (bnn_rst),
        .bnn_x      (bnn_x),
        .bnn_wnib   (bnn_wnib),
        .bnn_load_en(bnn_load_en),
        .bnn_y      (bnn_y),
        .busy       (busy),
        .load_done  (load_done)
    );

    always #5 clk = ~clk;

    // core model: h = popcount(xnor(x,w1[i])) >= 4, y likewise on h with w2
    // defaults: w1 all 0xFF, w2[3]=0xFF, others 0x00
    logic [7:0] w1 [8];
    logic [7:0] w2 [4];
    logic [4:0] ptr;
    logic [7:0] h_q;
    logic [3:0] y_q;

    function automatic logic [7:0] layer1(input logic [7:0] x);
        logic [7:0] h;
        for (int i = 0; i < 8; i++) h[i] = ($countones(~(x ^ w1[i])) >= 4);
        return h;
    endfunction

    function automatic logic [3:0] layer2(input logic [7:0] h);
        logic [3:0] y;
        for (int j = 0; j < 4; j++) y[j] = ($countones(~(h ^ w2[j])) >= 4);
        return y;
    endfunction

    always @(posedge clk) begin
        if (reset || bnn_rst) begin
            for (int i = 0; i < 8; i++) w1[i] <= 8'hFF;
            for (int j = 0; j < 4; j++) w2[j] <= (j == 3) ? 8'hFF : 8'h00;
            ptr <= 5'd0;
            h_q <= 8'h00;
            y_q <= 4'h0;
        end else begin
            if (bnn_load_en) begin
                if (ptr[4:1] < 4'd8) begin
                    if (ptr[0]) w1[ptr[3:1]][7:4] <= bnn_wnib;
                    else        w1[ptr[3:1]][3:0] <= bnn_wnib;
                end else if (ptr[4:1] < 4'd12) begin
                    if (ptr[0]) w2[ptr[2:1]][7:4] <= bnn_wnib;
                    else        w2[ptr[2:1]][3:0] <= bnn_wnib;
                end
                ptr <= ptr + 5'd1;
            end
            h_q <= layer1(bnn_x);
            y_q <= layer2(h_q);
        end
    end
    assign bnn_y = y_q;

    // strobe monitor, sampled mid-cycle
    int         cyc      = 0;
    int         le_cnt   = 0;
    int         rst_cnt  = 0;
    int         rst_cyc  = 0;
    int         done_cnt = 0;
    logic [3:0] nib_log [512];
    int         le_cyc  [512];

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (bnn_load_en) begin
            nib_log[le_cnt] <= bnn_wnib;
            le_cyc[le_cnt]  <= cyc;
            le_cnt          <= le_cnt + 1;
        end
        if (bnn_rst) begin
            rst_cnt <= rst_cnt + 1;
            rst_cyc <= cyc;
        end
        if (load_done) done_cnt <= done_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // full reload of 12 bytes of value b; optional 3-cycle stall after byte stall_at
    task automatic do_load(input logic [7:0] b, input int stall_at,
                           input bit pulse, input bit with_vec,
                           input logic [7:0] x, input bit chk);
        int sent, stall_left, nstall, le0, rst0, done0, bad;
        bit stalled;
        le0 = le_cnt;
        rst0 = rst_cnt;
        done0 = done_cnt;
        if (pulse) begin
            load_start = 1'b1;
            if (with_vec) begin
                bus.in_valid = 1'b1;
                bus.in_data  = x;
            end
            @(negedge clk);
            if (with_vec) check("load_wins_in_ready", bus.in_ready, 0);
            tick();
            load_start = 1'b0;
        end
        bus.cfg_valid = 1'b1;
        bus.cfg_data  = b;
        sent = 0;
        stall_left = 0;
        nstall = 0;
        stalled = 1'b0;
        for (int c = 0; c < 300 && sent < 12; c++) begin
            @(negedge clk);
            if (bus.cfg_ready && !bus.cfg_valid && stall_left > 0) begin
                stall_left--;
                nstall++;
                check("stall_load_en", bnn_load_en, 0);
            end
            if (bus.cfg_ready && bus.cfg_valid) sent++;
            tick();
            if (stall_at > 0 && sent == stall_at && !stalled) begin
                bus.cfg_valid = 1'b0;
                stalled = 1'b1;
                stall_left = 3;
            end else if (stalled && stall_left == 0) begin
                bus.cfg_valid = 1'b1;
            end
        end
        bus.cfg_valid = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (load_done) break;
        end
        check("load_done", load_done, 1);
        check("busy_drop", busy, 0);
        if (with_vec) check("vec_after_load", bus.in_ready, 1);
        tick();
        if (with_vec) bus.in_valid = 1'b0;
        @(negedge clk);
        check("load_done_once", load_done, 0);
        tick();
        if (chk) begin
            check("rst_pulses", rst_cnt - rst0, 1);
            check("done_pulses", done_cnt - done0, 1);
            check("strobes", le_cnt - le0, 24);
            check("stall_cycles", nstall, (stall_at > 0) ? 3 : 0);
            check("first_after_rst", le_cyc[le0] - rst_cyc, 1);
            check("strobe_span", le_cyc[le_cnt-1] - le_cyc[le0] + 1,
                  24 + nstall);
            bad = 0;
            for (int i = 0; i < 24; i++)
                if (nib_log[le0+i] !== ((i % 2 == 0) ? b[3:0] : b[7:4]))
                    bad++;
            check("nibble_seq_errs", bad, 0);
        end
    endtask

    // wait for a pending result, check it and complete the handshake
    task automatic finish_out(input logic [3:0] exp_y);
        for (int c = 0; c < 20 && !bus.out_valid; c++) tick();
        check("out_valid", bus.out_valid, 1);
        check("out_data", bus.out_data, exp_y);
        bus.out_ready = 1'b1;
        tick();
        check("out_released", bus.out_valid, 0);
        bus.out_ready = 1'b0;
    endtask

    task automatic do_infer(input logic [7:0] x, input logic [3:0] exp_y,
                            input int hold, input bit ld_hold,
                            input bit freeze);
        bit acc;
        int lat;
        bus.in_valid = 1'b1;
        bus.in_data  = x;
        acc = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                acc = 1'b1;
                break;
            end
            tick();
        end
        check("in_ready", acc, 1);
        tick();
        bus.in_valid = 1'b0;
        check("bnn_x", bnn_x, x);
        lat = 0;
        for (int c = 0; c < 20 && !bus.out_valid; c++) begin
            tick();
            lat++;
        end
        check("latency", lat, 3);
        check("out_data", bus.out_data, exp_y);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_valid", bus.out_valid, 1);
            check("hold_data", bus.out_data, exp_y);
            check("hold_in_ready", bus.in_ready, 0);
            tick();
            load_start = (ld_hold && i == 1);
        end
        load_start = 1'b0;
        if (freeze) begin
            ena = 1'b0;
            bus.out_ready = 1'b1;
            for (int i = 0; i < 2; i++) begin
                @(negedge clk);
                check("freeze_valid", bus.out_valid, 1);
                check("freeze_busy", busy, 1);
                tick();
            end
            ena = 1'b1;
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("valid_before_hs", bus.out_valid, 1);
        tick();
        bus.out_ready = 1'b0;
        check("valid_after_hs", bus.out_valid, 0);
        check("idle_after_hs", busy, 0);
        if (ld_hold) begin
            check("pend_in_ready", bus.in_ready, 0);
            tick();
            check("wrst_after_hold", bnn_rst, 1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        ena = 1'b1;
        load_start = 1'b0;
        bus.cfg_valid = 1'b0;
        bus.cfg_data = 8'h00;
        bus.in_valid = 1'b1;
        bus.in_data = 8'h00;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_cfg_ready", bus.cfg_ready, 0);
        check("rst_in_ready", bus.in_ready, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_data", bus.out_data, 0);
        check("rst_bnn_rst", bnn_rst, 0);
        check("rst_bnn_x", bnn_x, 0);
        check("rst_wnib", bnn_wnib, 0);
        check("rst_load_en", bnn_load_en, 0);
        check("rst_busy", busy, 0);
        check("rst_load_done", load_done, 0);
        tick();
        reset = 1'b0;
        bus.in_valid = 1'b0;

        // core defaults, held result and a frozen handshake
        do_infer(8'hFF, 4'b1000, 5, 1'b0, 1'b1);

        do_load(8'hA5, 0, 1'b1, 1'b0, 8'h00, 1'b1);
        do_load(8'hA5, 4, 1'b1, 1'b0, 8'h00, 1'b1);

        do_load(8'hFF, 0, 1'b1, 1'b0, 8'h00, 1'b1);
        do_infer(8'hFF, 4'hF, 0, 1'b0, 1'b0);
        do_load(8'h00, 0, 1'b1, 1'b0, 8'h00, 1'b1);
        do_infer(8'h00, 4'h0, 0, 1'b0, 1'b0);

        // load_start and in_valid together: load first, then the vector
        do_load(8'hFF, 0, 1'b1, 1'b1, 8'hFF, 1'b1);
        finish_out(4'hF);

        // load_start while a result is held
        do_infer(8'hFF, 4'hF, 3, 1'b1, 1'b0);
        do_load(8'h00, 0, 1'b0, 1'b0, 8'h00, 1'b0);
        do_infer(8'h00, 4'h0, 0, 1'b0, 1'b0);

        // reset in the middle of a reload
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        bus.cfg_valid = 1'b1;
        bus.cfg_data = 8'h3C;
        repeat (5) tick();
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("midrst_busy", busy, 0);
        check("midrst_load_en", bnn_load_en, 0);
        check("midrst_cfg_ready", bus.cfg_ready, 0);
        check("midrst_out_valid", bus.out_valid, 0);
        tick();
        reset = 1'b0;
        @(negedge clk);
        check("postrst_busy", busy, 0);
        check("postrst_load_en", bnn_load_en, 0);
        tick();
        bus.cfg_valid = 1'b0;
        do_infer(8'hFF, 4'b1000, 0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
